// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, line levels, frame sizing.
// Used by the transmit sequencer and intended for the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic TX_IDLE = 1'b1;

    // Baud ticks in one frame: start + data + optional parity + stop.
    function automatic int frame_ticks(
        input int data_bits,
        input int stop_bits,
        input bit parity_en
    );
        return 1 + data_bits + (parity_en ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Transmit shift register with bit-index counter.
// Loaded at frame start, shifted right once per data-bit tick.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic                 i_shift,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_bit,
    output logic                 o_next_bit,
    output logic                 o_last
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic [DATA_BITS-1:0] r_sreg;
    logic [IDX_W-1:0]     r_idx;

    // Load on handshake; shift and count on data ticks, index saturates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sreg <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
            r_idx  <= '0;
        end else if (i_shift) begin
            r_sreg <= {1'b0, r_sreg[DATA_BITS-1:1]};
            if (r_idx != LAST_IDX) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_bit      = r_sreg[0];
    assign o_next_bit = r_sreg[1];
    assign o_last     = (r_idx == LAST_IDX);

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer driving an external mod-N baud counter.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_baud_tick,
    output logic                 o_baud_en,
    output logic                 o_baud_clr,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam logic STOP_LAST = (STOP_BITS == 2);

    uart_state_e r_state;
    uart_state_e w_state_nx;

    logic r_tx;
    logic r_ready;
    logic r_busy;
    logic r_baud_en;
    logic r_baud_clr;
    logic r_stop_cnt;

    logic w_tx_nx;
    logic w_ready_nx;
    logic w_busy_nx;
    logic w_en_nx;
    logic w_clr_nx;
    logic w_stop_nx;
    logic w_load;
    logic w_shift;
    logic w_tick;
    logic w_bit;
    logic w_next_bit;
    logic w_last;

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    // Parity of the accepted byte, captured on the handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= (^i_data) ^ (PARITY_ODD != 0);
        end
    end
`else
    logic w_unused_parity_cfg;
    assign w_unused_parity_cfg = (PARITY_ODD != 0);
`endif

    // A tick landing in the counter-clear cycle belongs to the old count.
    assign w_tick = i_baud_tick & ~r_baud_clr;

    uart_tx_shifter #(
        .DATA_BITS (DATA_BITS)
    ) u_shifter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (i_data),
        .o_bit      (w_bit),
        .o_next_bit (w_next_bit),
        .o_last     (w_last)
    );

    // Next state and next registered output values.
    always_comb begin
        w_state_nx = r_state;
        w_tx_nx    = r_tx;
        w_ready_nx = r_ready;
        w_busy_nx  = r_busy;
        w_en_nx    = r_baud_en;
        w_clr_nx   = 1'b0;
        w_stop_nx  = r_stop_cnt;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_tx_nx    = TX_IDLE;
                w_busy_nx  = 1'b0;
                w_en_nx    = 1'b0;
                w_ready_nx = 1'b1;
                if (i_valid && r_ready) begin
                    w_load     = 1'b1;
                    w_state_nx = ST_START;
                    w_tx_nx    = 1'b0;
                    w_ready_nx = 1'b0;
                    w_busy_nx  = 1'b1;
                    w_en_nx    = 1'b1;
                    w_clr_nx   = 1'b1;
                    w_stop_nx  = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nx = ST_DATA;
                    w_tx_nx    = w_bit;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift = 1'b1;
                    if (w_last) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nx = ST_PARITY;
                        w_tx_nx    = r_parity;
`else
                        w_state_nx = ST_STOP;
                        w_tx_nx    = TX_IDLE;
`endif
                    end else begin
                        w_tx_nx = w_next_bit;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nx = ST_STOP;
                    w_tx_nx    = TX_IDLE;
                end
            end
`endif
            ST_STOP: begin
                w_tx_nx = TX_IDLE;
                if (w_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_state_nx = ST_IDLE;
                        w_en_nx    = 1'b0;
                        w_busy_nx  = 1'b0;
                        w_ready_nx = 1'b1;
                    end else begin
                        w_stop_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_tx_nx    = TX_IDLE;
                w_busy_nx  = 1'b0;
                w_en_nx    = 1'b0;
                w_ready_nx = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drives the line idle at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_tx       <= TX_IDLE;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_baud_en  <= 1'b0;
            r_baud_clr <= 1'b0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_tx       <= w_tx_nx;
            r_ready    <= w_ready_nx;
            r_busy     <= w_busy_nx;
            r_baud_en  <= w_en_nx;
            r_baud_clr <= w_clr_nx;
            r_stop_cnt <= w_stop_nx;
        end
    end

    assign o_tx       = r_tx;
    assign o_ready    = r_ready;
    assign o_busy     = r_busy;
    assign o_baud_en  = r_baud_en;
    assign o_baud_clr = r_baud_clr;

endmodule
